// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered multi-channel arbiter sharing one BRAM port, with latency-tagged read return
module mem_port_arbiter #(
  parameter int NCH = 4,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 1,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     lock_ch,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  logic [NCH-1:0] elig;
  logic [CW-1:0] ptr, win, gnt_idx, sel_lo, sel_rr;
  logic hit, hit_any, hit_lk, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [RD_LAT-1:0] pv;
  logic [CW-1:0] pt [RD_LAT];
  assign elig = req & ~gnt;
  assign busy = |pv;
  always_comb begin
    hit_any = 1'b0;
    hit_lk = 1'b0;
    sel_lo = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        hit_any = 1'b1;
        sel_lo = CW'(i);
      end
    end
    sel_rr = sel_lo;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i] && CW'(i) >= ptr) sel_rr = CW'(i);
    end
    for (int i = 0; i < NCH; i++) begin
      if (elig[i] && CW'(i) == lock_ch) hit_lk = 1'b1;
    end
    hit = (mode == 2'd2) ? hit_lk : hit_any;
    win = (mode == 2'd2) ? lock_ch : (mode == 2'd1) ? sel_lo : sel_rr;
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CW'(i) == win) begin
        sel_we = we[i];
        sel_addr = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      gnt <= '0;
      rvalid <= '0;
      rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ptr <= '0;
      gnt_idx <= '0;
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) pt[i] <= '0;
    end else begin
      gnt <= {{(NCH-1){1'b0}}, hit} << win;
      mem_en <= hit;
      mem_we <= hit & sel_we;
      if (hit) begin
        mem_addr <= sel_addr;
        mem_wdata <= sel_wdata;
        gnt_idx <= win;
      end
      if (hit && mode != 2'd1 && mode != 2'd2) ptr <= (win == CW'(NCH - 1)) ? '0 : win + CW'(1);
      pv[0] <= mem_en & ~mem_we;
      pt[0] <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
      end
      rvalid <= {{(NCH-1){1'b0}}, pv[RD_LAT-1]} << pt[RD_LAT-1];
      if (pv[RD_LAT-1]) rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter against a two-cycle BRAM model
module tb_mem_port_arbiter;
  localparam int NCH = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD_LAT = 2;
  typedef struct { int due; logic [NCH-1:0] ch; logic [DW-1:0] data; } exp_t;
  logic clk_100 = 1'b0;
  logic rst_n;
  logic [1:0] mode;
  logic [1:0] lock_ch;
  logic [NCH-1:0] req, we, gnt, rvalid;
  logic [NCH*AW-1:0] addr, snap_addr;
  logic [NCH*DW-1:0] wdata, snap_wdata;
  logic [NCH-1:0] snap_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata, rd1;
  logic [AW-1:0] mem_addr;
  logic busy, mem_en, mem_we, mon_on, exp_busy;
  logic [DW-1:0] bram [256];
  logic [DW-1:0] ref_mem [256];
  exp_t q[$];
  exp_t e;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .mode(mode), .lock_ch(lock_ch), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk_100 = ~clk_100;
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk_100);
    #1;
  endtask
  task automatic set_ch(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[ch] = w;
    addr[ch*AW +: AW] = a;
    wdata[ch*DW +: DW] = d;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = init_val(8'(i));
    rd1 = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk_100);
      if (mem_en && mem_we) bram[mem_addr[7:0]] <= mem_wdata;
      if (mem_en && !mem_we) rd1 <= bram[mem_addr[7:0]];
      mem_rdata <= rd1;
    end
  end
  always @(posedge clk_100) begin
    snap_we <= we;
    snap_addr <= addr;
    snap_wdata <= wdata;
  end
  initial forever begin
    @(negedge clk_100);
    cyc++;
    if (mon_on) begin
      exp_busy = 1'b0;
      foreach (q[i]) if (q[i].due > cyc && q[i].due - RD_LAT <= cyc) exp_busy = 1'b1;
      check("busy", 32'(busy), 32'(exp_busy));
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      check("mem_en", 32'(mem_en), 32'(|gnt));
      if (rvalid != '0) begin
        if (q.size() == 0) check("spurious_rvalid", 32'(rvalid), 32'd0);
        else begin
          e = q.pop_front();
          check("rvalid_ch", 32'(rvalid), 32'(e.ch));
          check("rdata", 32'(rdata), 32'(e.data));
          check("rvalid_cycle", cyc, e.due);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("missing_rvalid", 32'(rvalid), 32'(e.ch));
      end
      for (int k = 0; k < NCH; k++) begin
        if (gnt[k]) begin
          check("mem_addr", 32'(mem_addr), 32'(snap_addr[k*AW +: AW]));
          check("mem_we", 32'(mem_we), 32'(snap_we[k]));
          if (snap_we[k]) check("mem_wdata", 32'(mem_wdata), 32'(snap_wdata[k*DW +: DW]));
          else q.push_back('{due: cyc + RD_LAT + 1, ch: NCH'(1) << k, data: ref_mem[snap_addr[k*AW +: 8]]});
        end
      end
      if (!rst_n) q.delete();
    end
  end
  initial begin
    rst_n = 1'b0;
    mode = 2'd0;
    lock_ch = 2'd0;
    req = 4'b1111;
    we = '0;
    addr = '0;
    wdata = '0;
    mon_on = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 16'h0040 + 16'(i), 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    mon_on = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_gnt", 32'(gnt), 32'd1 << (i % 4));
    end
    req = '0;
    repeat (6) step();
    check("rr_idle_gnt", 32'(gnt), 32'd0);
    check("rr_drained", 32'(q.size()), 32'd0);
    mode = 2'd1;
    req = 4'b0110;
    step();
    check("fp_first", 32'(gnt), 32'b0010);
    req = 4'b0100;
    step();
    check("fp_next", 32'(gnt), 32'b0100);
    req = 4'b1001;
    step();
    check("fp_hold_a", 32'(gnt), 32'b0001);
    step();
    check("fp_hold_b", 32'(gnt), 32'b1000);
    step();
    check("fp_hold_c", 32'(gnt), 32'b0001);
    req = '0;
    mode = 2'd0;
    repeat (4) step();
    set_ch(2, 1'b0, 16'h0010, 16'h0);
    req = 4'b0100;
    step();
    check("rd_gnt", 32'(gnt), 32'b0100);
    req = '0;
    step();
    check("rd_busy1", 32'(busy), 32'd1);
    check("rd_rvalid1", 32'(rvalid), 32'd0);
    step();
    check("rd_busy2", 32'(busy), 32'd1);
    check("rd_rvalid2", 32'(rvalid), 32'd0);
    step();
    check("rd_rvalid", 32'(rvalid), 32'b0100);
    check("rd_data", 32'(rdata), 32'hBEEF);
    check("rd_busy3", 32'(busy), 32'd0);
    set_ch(1, 1'b1, 16'h0020, 16'h1234);
    req = 4'b0010;
    step();
    check("wr_gnt", 32'(gnt), 32'b0010);
    ref_mem[8'h20] = 16'h1234;
    req = '0;
    we = '0;
    step();
    check("wr_no_busy", 32'(busy), 32'd0);
    set_ch(0, 1'b0, 16'h0020, 16'h0);
    set_ch(3, 1'b0, 16'h0033, 16'h0);
    req = 4'b1001;
    step();
    check("rr_ptr_gnt", 32'(gnt), 32'b1000);
    req = 4'b0001;
    step();
    check("rr_ptr_next", 32'(gnt), 32'b0001);
    req = '0;
    repeat (5) step();
    check("b2b_drained", 32'(q.size()), 32'd0);
    mode = 2'd2;
    lock_ch = 2'd3;
    req = 4'b1011;
    step();
    check("lock_a", 32'(gnt), 32'b1000);
    step();
    check("lock_b", 32'(gnt), 32'b0000);
    step();
    check("lock_c", 32'(gnt), 32'b1000);
    mode = 2'd0;
    step();
    check("lock_release", 32'(gnt), 32'b0010);
    mode = 2'd2;
    req = 4'b0011;
    step();
    check("lock_block_a", 32'(gnt), 32'd0);
    step();
    check("lock_block_b", 32'(gnt), 32'd0);
    req = '0;
    mode = 2'd0;
    repeat (5) step();
    set_ch(1, 1'b0, 16'h0041, 16'h0);
    req = 4'b0010;
    step();
    check("mr_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    req = '0;
    step();
    check("mr_gnt_clr", 32'(gnt), 32'd0);
    check("mr_busy_clr", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mr_rvalid", 32'(rvalid), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
    end
    check("final_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
